// File: rtl/register_file.sv
// rtl/register_file.sv - 32-entry register file with writeback bypass and pending-write scoreboard
//
// Ports:
//   clk         - clock, all state updates on the rising edge
//   reset       - asynchronous active-low reset
//   rs1_i/rs2_i - read indices; rs1_used_i/rs2_used_i flag that decode consumes them
//   rs1data_o/rs2data_o - combinational read data, bypassed from writeback
//   issue_i/issue_we_i/issue_rd_i - instruction issuing from decode and its destination
//   regwren_i/rd_i/datawb_i       - writeback port
//   stall_o     - decode must hold; suppresses issue in the same cycle

module register_file #(
    parameter int                DWIDTH  = 32,
    parameter logic [DWIDTH-1:0] SP_INIT = 32'h0100_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic              rs1_used_i,
    input  logic              rs2_used_i,
    output logic [DWIDTH-1:0] rs1data_o,
    output logic [DWIDTH-1:0] rs2data_o,
    input  logic              issue_i,
    input  logic              issue_we_i,
    input  logic [4:0]        issue_rd_i,
    input  logic              regwren_i,
    input  logic [4:0]        rd_i,
    input  logic [DWIDTH-1:0] datawb_i,
    output logic              stall_o
);

    logic [DWIDTH-1:0] regs [32];
    logic [1:0]        cnt  [32];

    logic [31:0] wr_vec;   // register written this cycle
    logic [31:0] dec_vec;  // counter decrements this cycle (never below 0)
    logic [31:0] inc_vec;  // counter increments this cycle
    logic        issue_eff;
    logic        hazard1;
    logic        hazard2;
    logic        overflow;

    always_comb begin
        wr_vec  = '0;
        dec_vec = '0;
        for (int i = 1; i < 32; i++) begin
            wr_vec[i]  = regwren_i && (rd_i == 5'(i));
            dec_vec[i] = wr_vec[i] && (cnt[i] != 2'd0);
        end
    end

    // A read source is still pending if its count stays nonzero after this
    // cycle's writeback is taken into account; the bypass supplies the data.
    always_comb begin
        hazard1  = 1'b0;
        hazard2  = 1'b0;
        overflow = 1'b0;
        if (rs1_used_i && (rs1_i != 5'd0))
            hazard1 = (cnt[rs1_i] - {1'b0, dec_vec[rs1_i]}) != 2'd0;
        if (rs2_used_i && (rs2_i != 5'd0))
            hazard2 = (cnt[rs2_i] - {1'b0, dec_vec[rs2_i]}) != 2'd0;
        // A fourth outstanding write would wrap the 2-bit counter.
        if (issue_i && issue_we_i && (issue_rd_i != 5'd0))
            overflow = (cnt[issue_rd_i] == 2'd3) && !wr_vec[issue_rd_i];
    end

    assign stall_o   = hazard1 || hazard2 || overflow;
    assign issue_eff = issue_i && issue_we_i && (issue_rd_i != 5'd0) && !stall_o;

    always_comb begin
        inc_vec = '0;
        for (int i = 1; i < 32; i++)
            inc_vec[i] = issue_eff && (issue_rd_i == 5'(i));
    end

    always_comb begin
        rs1data_o = '0;
        if (rs1_i != 5'd0)
            rs1data_o = wr_vec[rs1_i] ? datawb_i : regs[rs1_i];
    end

    always_comb begin
        rs2data_o = '0;
        if (rs2_i != 5'd0)
            rs2data_o = wr_vec[rs2_i] ? datawb_i : regs[rs2_i];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= (i == 2) ? SP_INIT : '0;
        end else begin
            for (int i = 1; i < 32; i++)
                if (wr_vec[i])
                    regs[i] <= datawb_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++)
                cnt[i] <= 2'd0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (inc_vec[i] && !dec_vec[i])
                    cnt[i] <= cnt[i] + 2'd1;
                else if (dec_vec[i] && !inc_vec[i])
                    cnt[i] <= cnt[i] - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed vector bench for register_file

module tb_register_file;

    logic        clk;
    logic        reset;
    logic [4:0]  rs1_i, rs2_i;
    logic        rs1_used_i, rs2_used_i;
    logic [31:0] rs1data_o, rs2data_o;
    logic        issue_i, issue_we_i;
    logic [4:0]  issue_rd_i;
    logic        regwren_i;
    logic [4:0]  rd_i;
    logic [31:0] datawb_i;
    logic        stall_o;

    int n_cmp;
    int n_err;

    register_file #(.DWIDTH(32), .SP_INIT(32'h0100_0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .rs1_i      (rs1_i),
        .rs2_i      (rs2_i),
        .rs1_used_i (rs1_used_i),
        .rs2_used_i (rs2_used_i),
        .rs1data_o  (rs1data_o),
        .rs2data_o  (rs2data_o),
        .issue_i    (issue_i),
        .issue_we_i (issue_we_i),
        .issue_rd_i (issue_rd_i),
        .regwren_i  (regwren_i),
        .rd_i       (rd_i),
        .datawb_i   (datawb_i),
        .stall_o    (stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic        iss;
        logic        iwe;
        logic [4:0]  ird;
        logic        wen;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        es;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                                logic iss, logic iwe, logic [4:0] ird,
                                logic wen, logic [4:0] rd, logic [31:0] wd,
                                logic [31:0] e1, logic [31:0] e2, logic es);
        vec_t v;
        v.rst = rst; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
        v.iss = iss; v.iwe = iwe; v.ird = ird;
        v.wen = wen; v.rd = rd; v.wd = wd;
        v.e1 = e1; v.e2 = e2; v.es = es;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset      = v.rst;
        rs1_i      = v.rs1;  rs1_used_i = v.u1;
        rs2_i      = v.rs2;  rs2_used_i = v.u2;
        issue_i    = v.iss;  issue_we_i = v.iwe; issue_rd_i = v.ird;
        regwren_i  = v.wen;  rd_i       = v.rd;  datawb_i   = v.wd;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        drive(mk(0, 0,0, 0,0, 0,0,0, 0,0,32'h0, 0,0,0));

        // reset and basic reads/bypass
        tbl.push_back(mk(0, 2,0, 0,0, 0,0,0,  0,0,32'h0,         32'h0100_0000, 32'h0, 0));
        tbl.push_back(mk(1, 2,0, 0,0, 0,0,0,  0,0,32'h0,         32'h0100_0000, 32'h0, 0));
        tbl.push_back(mk(1, 5,0, 0,0, 0,0,0,  1,5,32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0, 0));
        tbl.push_back(mk(1, 5,0, 0,0, 0,0,0,  0,0,32'h0,         32'hDEAD_BEEF, 32'h0, 0));
        // issue rd=7, hazard, writeback releases in the same cycle
        tbl.push_back(mk(1, 0,0, 0,0, 1,1,7,  0,0,32'h0,         32'h0, 32'h0, 0));
        tbl.push_back(mk(1, 0,0, 7,1, 0,0,0,  0,0,32'h0,         32'h0, 32'h0, 1));
        tbl.push_back(mk(1, 0,0, 7,1, 0,0,0,  1,7,32'h1234_5678, 32'h0, 32'h1234_5678, 0));
        tbl.push_back(mk(1, 0,0, 7,1, 0,0,0,  0,0,32'h0,         32'h0, 32'h1234_5678, 0));
        // fill x9's counter to 3, fourth issue stalls
        tbl.push_back(mk(1, 0,0, 0,0, 1,1,9,  0,0,32'h0,         32'h0, 32'h0, 0));
        tbl.push_back(mk(1, 0,0, 0,0, 1,1,9,  0,0,32'h0,         32'h0, 32'h0, 0));
        tbl.push_back(mk(1, 0,0, 0,0, 1,1,9,  0,0,32'h0,         32'h0, 32'h0, 0));
        tbl.push_back(mk(1, 0,0, 0,0, 1,1,9,  0,0,32'h0,         32'h0, 32'h0, 1));
        // issue + writeback same cycle: no stall, counter stays 3
        tbl.push_back(mk(1, 9,0, 0,0, 1,1,9,  1,9,32'hAAAA_0009, 32'hAAAA_0009, 32'h0, 0));
        tbl.push_back(mk(1, 9,1, 0,0, 0,0,0,  0,0,32'h0,         32'hAAAA_0009, 32'h0, 1));
        tbl.push_back(mk(1, 9,0, 0,0, 1,1,9,  0,0,32'h0,         32'hAAAA_0009, 32'h0, 1));
        // drain 3 -> 0, then extra writeback must not underflow
        tbl.push_back(mk(1, 9,1, 0,0, 0,0,0,  1,9,32'd9,         32'd9,  32'h0, 1));
        tbl.push_back(mk(1, 9,1, 0,0, 0,0,0,  1,9,32'd10,        32'd10, 32'h0, 1));
        tbl.push_back(mk(1, 9,1, 0,0, 0,0,0,  1,9,32'd11,        32'd11, 32'h0, 0));
        tbl.push_back(mk(1, 9,1, 0,0, 0,0,0,  1,9,32'd12,        32'd12, 32'h0, 0));
        tbl.push_back(mk(1, 9,1, 0,0, 0,0,0,  0,0,32'h0,         32'd12, 32'h0, 0));
        // x0 is never written and never stalls
        tbl.push_back(mk(1, 0,1, 0,1, 1,1,0,  1,0,32'hFFFF_FFFF, 32'h0, 32'h0, 0));
        tbl.push_back(mk(1, 0,1, 0,1, 1,1,0,  0,0,32'h0,         32'h0, 32'h0, 0));
        // unused source never stalls; a stalled issue is suppressed
        tbl.push_back(mk(1, 0,0, 0,0, 1,1,3,  0,0,32'h0,         32'h0, 32'h0, 0));
        tbl.push_back(mk(1, 3,0, 0,0, 0,0,0,  0,0,32'h0,         32'h0, 32'h0, 0));
        tbl.push_back(mk(1, 0,0, 3,1, 1,1,10, 0,0,32'h0,         32'h0, 32'h0, 1));
        tbl.push_back(mk(1, 0,0, 3,1, 0,0,0,  1,3,32'd33,        32'h0, 32'd33, 0));
        tbl.push_back(mk(1, 10,1, 0,0, 0,0,0, 0,0,32'h0,         32'h0, 32'h0, 0));

        repeat (2) @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            check($sformatf("v%0d rs1data", i), rs1data_o, tbl[i].e1);
            check($sformatf("v%0d rs2data", i), rs2data_o, tbl[i].e2);
            check($sformatf("v%0d stall", i), {31'b0, stall_o}, {31'b0, tbl[i].es});
        end

        // two pending writes to x4, then asynchronous reset mid-cycle
        @(negedge clk);
        drive(mk(1, 0,0, 0,0, 1,1,4, 0,0,32'h0, 0,0,0));
        @(negedge clk);
        drive(mk(1, 0,0, 0,0, 1,1,4, 0,0,32'h0, 0,0,0));
        @(negedge clk);
        drive(mk(1, 4,1, 0,0, 0,0,0, 0,0,32'h0, 0,0,0));
        #1;
        check("x4 pending stall", {31'b0, stall_o}, 32'd1);
        #1;
        drive(mk(0, 5,0, 2,0, 0,0,0, 0,0,32'h0, 0,0,0));
        #1;
        check("async clr x5", rs1data_o, 32'h0);
        check("async sp x2", rs2data_o, 32'h0100_0000);
        check("reset stall", {31'b0, stall_o}, 32'd0);
        // a writeback presented during reset must not land
        @(negedge clk);
        drive(mk(0, 0,0, 0,0, 1,1,4, 1,4,32'h55, 0,0,0));
        @(negedge clk);
        drive(mk(0, 0,0, 0,0, 0,0,0, 0,0,32'h0, 0,0,0));
        @(negedge clk);
        drive(mk(1, 4,1, 2,0, 0,0,0, 0,0,32'h0, 0,0,0));
        #1;
        check("post-reset x4", rs1data_o, 32'h0);
        check("post-reset sp", rs2data_o, 32'h0100_0000);
        check("post-reset stall", {31'b0, stall_o}, 32'd0);
        @(negedge clk);
        drive(mk(1, 7,0, 5,0, 0,0,0, 0,0,32'h0, 0,0,0));
        #1;
        check("post-reset x7", rs1data_o, 32'h0);
        check("post-reset x5", rs2data_o, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 32, meaning register and data width.
REQ-002 The block SHALL have parameter SP_INIT, default 32'h0100_0000, meaning the reset value of x2 (stack pointer).
REQ-003 The block SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 The block SHALL have port rs1_i  input  5  read port 1 register index.
REQ-006 The block SHALL have port rs2_i  input  5  read port 2 register index.
REQ-007 The block SHALL have port rs1_used_i  input  1  the instruction in decode reads rs1.
REQ-008 The block SHALL have port rs2_used_i  input  1  the instruction in decode reads rs2.
REQ-009 The block SHALL have port rs1data_o  output  DWIDTH  read data for rs1_i, combinational.
REQ-010 The block SHALL have port rs2data_o  output  DWIDTH  read data for rs2_i, combinational.
REQ-011 The block SHALL have port issue_i  input  1  the decode-stage instruction issues this cycle.
REQ-012 The block SHALL have port issue_we_i  input  1  the issuing instruction writes a destination register.
REQ-013 The block SHALL have port issue_rd_i  input  5  destination index of the issuing instruction.
REQ-014 The block SHALL have port regwren_i  input  1  writeback enable from the writeback stage.
REQ-015 The block SHALL have port rd_i  input  5  writeback destination index.
REQ-016 The block SHALL have port datawb_i  input  DWIDTH  writeback data (ALU result, load data, or PC+4).
REQ-017 The block SHALL have port stall_o  output  1  decode must hold; issue is suppressed this cycle.

Function
REQ-018 Storage SHALL be 32 registers x DWIDTH; x0 SHALL always read 0 and SHALL never be written.
REQ-019 Writes SHALL occur at the rising edge of clk when regwren_i=1 and rd_i!=0.
REQ-020 Reads SHALL bypass: if regwren_i=1, rd_i!=0 and rd_i equals the read index, read data SHALL equal datawb_i in the same cycle.
REQ-021 Each register x1..x31 SHALL have a 2-bit pending-write counter; x0's counter SHALL be constant 0.
REQ-022 Effective issue SHALL be issue_i=1 AND issue_we_i=1 AND issue_rd_i!=0 AND stall_o=0.
REQ-023 Counter update per register: +1 on effective issue only; -1 on writeback only (regwren_i=1, rd_i matches); unchanged when both occur in the same cycle or neither.
REQ-024 A writeback to a register whose counter is 0 SHALL still update data and SHALL leave the counter at 0 (no underflow).
REQ-025 stall_o SHALL be 1 when rs1_used_i=1 and rs1_i's counter minus this cycle's writeback decrement is nonzero; same rule for rs2.
REQ-026 stall_o SHALL be 1 when issue_i=1, issue_we_i=1 and issue_rd_i's counter is 3 and no writeback to it occurs this cycle (overflow guard).
REQ-027 stall_o SHALL be combinational from inputs and current counters; latency from writeback to stall release SHALL be 0 cycles (bypass covers the data).
REQ-028 Reads of x0, or with rsN_used_i=0, SHALL never cause a stall.

Reset
REQ-029 While reset=0, all registers SHALL be 0 except x2=SP_INIT, and all counters SHALL be 0, asynchronously.
REQ-030 Reset asserted mid-operation SHALL discard all pending counts and in-flight writes; no write SHALL occur on an edge where reset=0.
REQ-031 stall_o SHALL be 0 during reset given rsN_used_i=0, and SHALL depend only on inputs otherwise.

Verification
REQ-032 Reset release, read rs1_i=2, rs2_i=0 -> rs1data_o=32'h0100_0000, rs2data_o=0, stall_o=0.
REQ-033 Writeback rd_i=5, datawb_i=32'hDEAD_BEEF, rs1_i=5 same cycle -> rs1data_o=32'hDEAD_BEEF immediately; still so next cycle.
REQ-034 Issue rd=7; next cycle rs2_used_i=1, rs2_i=7 -> stall_o=1; writeback rd_i=7 that cycle -> stall_o=0, rs2data_o=datawb_i; counter returns to 0.
REQ-035 Three issues to rd=9 without writeback, fourth issue attempt -> stall_o=1, counter holds 3; issue and writeback to rd=9 same cycle -> counter unchanged.
REQ-036 Writeback rd_i=0, datawb_i=32'hFFFF_FFFF; issue_rd_i=0 -> x0 reads 0, never stalls.
REQ-037 Two pending writes to rd=4, assert reset=0 mid-cycle -> all counters 0, x4=0, stall_o=0 on rs1_i=4 after release.
